// File: rtl/booth_mul_rr_scheduler.sv
// booth_mul_rr_scheduler
// Shares one external 8x8 unsigned multiplier (MUL_LAT cycles of latency)
// between NREQ requesters. A round-robin arbiter issues at most one operation
// per cycle. Each result is captured into a small FIFO and returned in issue
// order, tagged with the requester index. Issue credit counts in-flight plus
// queued results, so the FIFO can never overflow.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (req_ready is a one-hot grant)
//   req_x, req_y          packed operands, requester i at [8i+7:8i]
//   mul_x, mul_y, mul_p   interface to the shared multiplier
//   resp_valid/ready      result stream handshake
//   resp_p, resp_id       product and requester index at the FIFO head
//   busy                  work in flight or results queued
module booth_mul_rr_scheduler #(
    parameter int NREQ       = 4,
    parameter int IDW        = 2,
    parameter int MUL_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*8-1:0]   req_x,
    input  logic [NREQ*8-1:0]   req_y,
    output logic [7:0]          mul_x,
    output logic [7:0]          mul_y,
    input  logic [15:0]         mul_p,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [15:0]         resp_p,
    output logic [IDW-1:0]      resp_id,
    output logic                busy
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 2;

    logic [IDW-1:0]   ptr_r;
    logic [MUL_LAT-1:0] infl_v_r;
    logic [IDW-1:0]   infl_id_r [MUL_LAT];
    logic [15:0]      mem_p_r   [FIFO_DEPTH];
    logic [IDW-1:0]   mem_id_r  [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    fifo_cnt_r;
    logic [15:0]      resp_p_r;
    logic [IDW-1:0]   resp_id_r;

    logic [CW-1:0]    infl_cnt_s;
    logic             issue_ok_s;
    logic             grant_v_s;
    logic [IDW-1:0]   grant_id_s;
    logic             push_s;
    logic             pop_s;
    logic [PW-1:0]    rd_next_s;
    logic [CW-1:0]    cnt_next_s;
    logic [15:0]      head_p_s;
    logic [IDW-1:0]   head_id_s;

    // Credit: a pop in this same cycle is deliberately not counted.
    always_comb begin
        infl_cnt_s = {CW{1'b0}};
        for (int i = 0; i < MUL_LAT; i++) begin
            infl_cnt_s = infl_cnt_s + CW'(infl_v_r[i]);
        end
        issue_ok_s = ((infl_cnt_s + fifo_cnt_r) < CW'(FIFO_DEPTH));
    end

    // Round-robin search starting at ptr_r; no grant while held in reset.
    always_comb begin
        logic [IDW-1:0] idx;
        grant_v_s  = 1'b0;
        grant_id_s = {IDW{1'b0}};
        idx        = {IDW{1'b0}};
        if (rst_n && issue_ok_s) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = IDW'((int'(ptr_r) + k) % NREQ);
                if (!grant_v_s && req_valid[idx]) begin
                    grant_v_s  = 1'b1;
                    grant_id_s = idx;
                end else begin
                    grant_v_s  = grant_v_s;
                end
            end
        end else begin
            grant_v_s = 1'b0;
        end
    end

    // Grant decode and operand steering to the shared multiplier.
    always_comb begin
        req_ready = {NREQ{1'b0}};
        mul_x     = 8'd0;
        mul_y     = 8'd0;
        if (grant_v_s) begin
            req_ready[grant_id_s] = 1'b1;
            mul_x = req_x[{grant_id_s, 3'b000} +: 8];
            mul_y = req_y[{grant_id_s, 3'b000} +: 8];
        end else begin
            req_ready = {NREQ{1'b0}};
        end
    end

    assign push_s     = infl_v_r[MUL_LAT-1];
    assign resp_valid = (fifo_cnt_r != {CW{1'b0}});
    assign pop_s      = resp_valid & resp_ready;
    assign rd_next_s  = rd_ptr_r + PW'(pop_s);
    assign cnt_next_s = fifo_cnt_r + CW'(push_s) - CW'(pop_s);

    // Next head value: bypass the pushed entry when it lands in an empty FIFO.
    always_comb begin
        head_p_s  = resp_p_r;
        head_id_s = resp_id_r;
        if (cnt_next_s != {CW{1'b0}}) begin
            if (push_s && (fifo_cnt_r == CW'(pop_s))) begin
                head_p_s  = mul_p;
                head_id_s = infl_id_r[MUL_LAT-1];
            end else begin
                head_p_s  = mem_p_r[rd_next_s];
                head_id_s = mem_id_r[rd_next_s];
            end
        end else begin
            head_p_s  = resp_p_r;
            head_id_s = resp_id_r;
        end
    end

    // Pointer, in-flight pipe, FIFO storage and registered head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r      <= {IDW{1'b0}};
            infl_v_r   <= {MUL_LAT{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            fifo_cnt_r <= {CW{1'b0}};
            resp_p_r   <= 16'd0;
            resp_id_r  <= {IDW{1'b0}};
            for (int i = 0; i < MUL_LAT; i++) begin
                infl_id_r[i] <= {IDW{1'b0}};
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_p_r[i]  <= 16'd0;
                mem_id_r[i] <= {IDW{1'b0}};
            end
        end else begin
            if (grant_v_s) begin
                ptr_r <= IDW'((int'(grant_id_s) + 1) % NREQ);
            end else begin
                ptr_r <= ptr_r;
            end
            infl_v_r[0]  <= grant_v_s;
            infl_id_r[0] <= grant_id_s;
            for (int i = 1; i < MUL_LAT; i++) begin
                infl_v_r[i]  <= infl_v_r[i-1];
                infl_id_r[i] <= infl_id_r[i-1];
            end
            if (push_s) begin
                mem_p_r[wr_ptr_r]  <= mul_p;
                mem_id_r[wr_ptr_r] <= infl_id_r[MUL_LAT-1];
                wr_ptr_r           <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            rd_ptr_r   <= rd_next_s;
            fifo_cnt_r <= cnt_next_s;
            resp_p_r   <= head_p_s;
            resp_id_r  <= head_id_s;
        end
    end

    assign resp_p  = resp_p_r;
    assign resp_id = resp_id_r;
    assign busy    = (|infl_v_r) | (fifo_cnt_r != {CW{1'b0}});

endmodule
